// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: none (package only).
// Backpressure: none (package only).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit code the seven-segment decoder renders as all segments off
  localparam logic [3:0] BLANK_CODE  = 4'hF;
  // Largest legal decimal digit, used for the saturated overflow result
  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  // Digits at or above this value get +3 before each shift
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is >= 5.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), saturating to all 9s on overflow.
// Latency: done_o in the cycle after edge k+BIN_W+1 for an accept at edge k; BIN_W+2 cycles per result.
// Backpressure: ready_o is high only in IDLE; start_i while busy is dropped. Build option BCD_LZ_BLANK_EN blanks leading zeros.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_ready;
  logic               w_accept;

  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;

  logic [BCD_W-1:0]   w_acc_add;
  logic [BCD_W-1:0]   w_acc_shift;
  logic [BIN_W-1:0]   w_bin_shift;
  logic [BCD_W-1:0]   w_result;

  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_done;

  // Add-3 correction on every accumulator digit, applied before the shift
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
        .i_digit (r_acc[4*g +: 4]),
        .o_digit (w_acc_add[4*g +: 4])
      );
    end
  endgenerate

  // The top accumulator bit falls off the end; the binary MSB enters at the bottom
  assign w_acc_shift = {w_acc_add[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_bin_shift = {r_bin[BIN_W-2:0], 1'b0};
  assign w_accept    = start_i && w_ready;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (start_i) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Counter reaches zero with this shift
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shift datapath: load on accept, one add-3/shift step per SHIFT cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bin    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_bin    <= bin_i;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(BIN_W);
      r_sticky <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_bin <= w_bin_shift;
      r_acc <= w_acc_shift;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_acc_add[BCD_W-1]) begin
        r_sticky <= 1'b1;
      end
    end
  end

  // Final result: saturate on overflow, otherwise optionally blank leading zeros
  always_comb begin
    w_result = r_acc;
    if (r_sticky) begin
      for (int d = 0; d < DIGITS; d++) begin
        w_result[4*d +: 4] = DIGIT_MAX;
      end
    end else begin
`ifdef BCD_LZ_BLANK_EN
      // Walk down from the top digit; digit 0 always stays visible
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (w_result[4*(d+1) +: 4*(DIGITS-d)] == {(DIGITS-d){BLANK_CODE}}
            || d == DIGITS - 1) begin
          if (r_acc[4*d +: 4] == 4'd0 &&
              (d == DIGITS - 1 || w_result[4*(d+1) +: 4] == BLANK_CODE)) begin
            w_result[4*d +: 4] = BLANK_CODE;
          end
        end
      end
`endif
    end
  end

  // Output register: capture result and pulse done while leaving DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_bcd <= w_result;
        r_ovf <= r_sticky;
      end
    end
  end

  assign ready_o = w_ready;
  assign bcd_o   = r_bcd;
  assign done_o  = r_done;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench: two converters (2 and 3 digits) with a scoreboard per instance.
// Latency: expected done cycle is stored with each expected result.
// Backpressure: accepts are logged only when start_i && ready_o.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        st2 = 1'b0, st3 = 1'b0;
  logic [7:0]  b2 = '0, b3 = '0;
  logic        rdy2, dn2, ov2;
  logic        rdy3, dn3, ov3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;

  bcd_seq_converter #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st2), .bin_i(b2),
    .ready_o(rdy2), .bcd_o(bcd2), .done_o(dn2), .ovf_o(ov2)
  );

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(st3), .bin_i(b3),
    .ready_o(rdy3), .bcd_o(bcd3), .done_o(dn3), .ovf_o(ov3)
  );

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last2  = 0;
  bit have_last2 = 1'b0;
  bit b2b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference conversion using plain division
  function automatic exp_t model(input int v, input int nd);
    exp_t r;
    int   lim;
    int   p;
    bit   lead;
    logic [3:0] dg;
    r.bcd = '0;
    r.ovf = 1'b0;
    r.cyc = 0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) begin
      r.ovf = 1'b1;
      for (int d = 0; d < nd; d++) r.bcd[4*d +: 4] = 4'd9;
    end else begin
      p = 1;
      for (int d = 0; d < nd; d++) begin
        dg = 4'((v / p) % 10);
        r.bcd[4*d +: 4] = dg;
        p = p * 10;
      end
`ifdef BCD_LZ_BLANK_EN
      lead = 1'b1;
      for (int d = nd - 1; d >= 1; d--) begin
        if (lead && r.bcd[4*d +: 4] == 4'd0) r.bcd[4*d +: 4] = 4'hF;
        else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
    end
    return r;
  endfunction

  // Monitor: log accepts, compare results on done
  always @(negedge clk) begin
    if (!rst) begin
      if (dn2) begin
        if (q2.size() == 0) begin
          check("d2_spurious_done", 64'(dn2), 64'd0);
        end else begin
          e2 = q2.pop_front();
          check("d2_bcd", 64'(bcd2), 64'(e2.bcd[7:0]));
          check("d2_ovf", 64'(ov2), 64'(e2.ovf));
          check("d2_done_cyc", 64'(cyc), 64'(e2.cyc));
          check("d2_ready_at_done", 64'(rdy2), 64'd1);
        end
      end
      if (st2 && rdy2) begin
        e2 = model(int'(b2), 2);
        e2.cyc = cyc + 10;
        q2.push_back(e2);
        if (b2b && have_last2) check("d2_b2b_gap", 64'(cyc - last2), 64'd10);
        last2 = cyc;
        have_last2 = 1'b1;
      end
      if (dn3) begin
        if (q3.size() == 0) begin
          check("d3_spurious_done", 64'(dn3), 64'd0);
        end else begin
          e3 = q3.pop_front();
          check("d3_bcd", 64'(bcd3), 64'(e3.bcd));
          check("d3_ovf", 64'(ov3), 64'(e3.ovf));
          check("d3_done_cyc", 64'(cyc), 64'(e3.cyc));
        end
      end
      if (st3 && rdy3) begin
        e3 = model(int'(b3), 3);
        e3.cyc = cyc + 10;
        q3.push_back(e3);
      end
    end
  end

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 2) ? q2.size() : q3.size()) != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'((sel == 2) ? q2.size() : q3.size()), 64'd0);
    @(posedge clk);
  endtask

  task automatic run(input int sel, input logic [7:0] v);
    @(posedge clk) #1;
    if (sel == 2) begin st2 = 1'b1; b2 = v; end
    else          begin st3 = 1'b1; b3 = v; end
    @(posedge clk) #1;
    st2 = 1'b0;
    st3 = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'((sel == 2) ? rdy2 : rdy3), 64'd0);
    drain(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(rdy2), 64'd1);
    check("rst_done",  64'(dn2),  64'd0);
    check("rst_bcd",   64'(bcd2), 64'd0);
    check("rst_ovf",   64'(ov2),  64'd0);
    check("rst_bcd3",  64'(bcd3), 64'd0);
    @(posedge clk) #3 rst = 1'b0;
    repeat (2) @(posedge clk);

    // 2-digit instance: nominal, overflow, zero
    run(2, 8'd57);
    run(2, 8'd100);
    run(2, 8'd0);
    run(2, 8'd99);

    // 3-digit instance: full range, then a start while busy must be dropped
    @(posedge clk) #1;
    st3 = 1'b1; b3 = 8'd255;
    @(posedge clk) #1;
    st3 = 1'b0; b3 = 8'd1;
    repeat (3) @(posedge clk);
    #1 st3 = 1'b1; b3 = 8'd7;
    @(posedge clk) #1 st3 = 1'b0;
    drain(3);
    run(3, 8'd128);
    run(3, 8'd7);
    run(3, 8'd0);
    run(3, 8'd40);

    // Back-to-back accepts with bin_i changing every cycle
    b2b = 1'b1;
    have_last2 = 1'b0;
    @(posedge clk) #1;
    st2 = 1'b1; b2 = 8'($urandom_range(0, 255));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk) #1;
      b2 = 8'($urandom_range(0, 255));
    end
    st2 = 1'b0;
    b2b = 1'b0;
    drain(2);
    run(2, 8'd63);

    // Asynchronous reset in the middle of a conversion
    @(posedge clk) #1;
    st2 = 1'b1; b2 = 8'd99;
    @(posedge clk) #1 st2 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    q2.delete();
    check("mid_rst_ready", 64'(rdy2), 64'd1);
    check("mid_rst_done",  64'(dn2),  64'd0);
    check("mid_rst_bcd",   64'(bcd2), 64'd0);
    check("mid_rst_ovf",   64'(ov2),  64'd0);
    @(posedge clk);
    @(posedge clk) #3 rst = 1'b0;
    repeat (15) @(posedge clk);
    run(2, 8'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, parametrised in input width and output digit count.
Replaces the single-cycle divide/modulo conversion in the scoreboard display path with a small, divider-free iterative datapath.
A valid/ready start handshake, a done pulse and saturating overflow make it usable in front of the seven-segment digit drivers for any score width.

Parameters:
BIN_W, 8, width of the binary input in bits (legal range 4..32).
DIGITS, 2, number of BCD output digits (legal range 1..10); maximum representable value is 10^DIGITS-1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  reset, asynchronous, active-high.
start_i  input  1  request a conversion of bin_i.
bin_i  input  BIN_W  unsigned binary value; sampled only on the accept edge.
ready_o  output  1  high in IDLE only; a conversion is accepted when start_i && ready_o at a rising edge.
bcd_o  output  4*DIGITS  result; digit 0 (least significant) in bits [3:0]; holds its value until the next done.
done_o  output  1  single-cycle pulse; bcd_o and ovf_o are valid from this cycle onward.
ovf_o  output  1  last result exceeded 10^DIGITS-1; held with bcd_o.

Behaviour:
- Reset, asynchronous: state=IDLE, ready_o=1, done_o=0, ovf_o=0, bcd_o=all zeros (also when the optional feature is compiled in), internal shift register and counter cleared.
- Reset mid-conversion aborts it immediately. No done_o is produced. The bench must observe the reset values.
- States and transitions:
  - IDLE: on accept, load bin_i into the binary shift register, clear the BCD accumulator and the sticky overflow flag, set the counter to BIN_W, go to SHIFT.
  - SHIFT: each cycle performs two steps. First, add 3 to every accumulator digit >= 5. Then shift {accumulator, binary} left by one and decrement the counter. Any 1 bit shifted out of the top digit sets the sticky overflow flag. When the counter reaches 0 after the shift, go to DONE.
  - DONE: register the result into bcd_o and ovf_o, pulse done_o for one cycle, return to IDLE.
- Latency: the accept edge is edge k. done_o is high, and bcd_o/ovf_o are updated, in the cycle following edge k+BIN_W+1. ready_o is high again in that same cycle.
- Throughput: one conversion per BIN_W+2 cycles. A start_i held high back-to-back is accepted in the cycle after done_o.
- start_i while ready_o=0 is ignored, not queued. bin_i changes during a conversion have no effect.
- Overflow: if the sticky flag is set, bcd_o saturates to all digits = 9 and ovf_o=1. Otherwise ovf_o=0.
- Digit values on bcd_o are always 0..9, except for the blank code when the optional feature is enabled.
- Counter width: clog2(BIN_W+1). There is no wrap-around.

Optional Feature:
BCD_LZ_BLANK_EN
- Defined: in the registered result, every leading zero digit above digit 0 is replaced by BLANK_CODE (4'hF); the seven-segment decoder shows 4'hF as all segments off. Digit 0 is never blanked, so value 0 shows "0". No blanking is applied to a saturated overflow result. Latency is unchanged; the blanking is computed combinationally in the DONE stage.
- Undefined: leading zeros are output as 4'h0.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - BLANK_CODE = 4'hF
  - DIGIT_MAX = 4'd9
  - ADD3_THRESH = 4'd5
- Sub-module bcd_add3_digit: combinational, 4-bit in/out, adds 3 when the input is >= 5. It is instantiated DIGITS times via generate. All other logic stays in bcd_seq_converter.

Test Plan:
- BIN_W=8, DIGITS=2: reset, then start with bin_i=8'd57 -> ready_o drops; done_o pulses 10 cycles after the accept edge; bcd_o=8'h57, ovf_o=0; ready_o=1 in the done cycle.
- BIN_W=8, DIGITS=2: bin_i=8'd100 -> bcd_o=8'h99, ovf_o=1. Then bin_i=8'd0 -> bcd_o=8'h00, ovf_o=0.
- BIN_W=8, DIGITS=3: bin_i=8'd255 -> bcd_o=12'h255, ovf_o=0. Then start_i pulsed during SHIFT with bin_i=8'd7 -> ignored; the next accepted value only is converted.
- start_i held high with bin_i changing each cycle -> accepts occur exactly every 10 cycles; each bcd_o matches the bin_i sampled at its own accept edge.
- rst_i asserted asynchronously mid-SHIFT (4 cycles after accepting 8'd99) -> outputs take reset values immediately, no done_o. A new start after reset converts correctly.
- BCD_LZ_BLANK_EN defined, BIN_W=8, DIGITS=3:
  - bin_i=8'd7 -> bcd_o=12'hFF7
  - bin_i=8'd0 -> bcd_o=12'hFF0
  - bin_i=8'd40 -> bcd_o=12'hF40
  - without the macro, bin_i=8'd7 -> bcd_o=12'h007.
